// File: rtl/fft_r22sdf_bfii.sv
// -----------------------------------------------------------------------------
// fft_r22sdf_bfii
//
// Radix-2^2 single-path delay-feedback FFT butterfly, type II stage.
// This stage follows the type-I butterfly of an R2^2SDF stage pair. In the
// fourth quarter of every 4*L-sample block it multiplies the input by -j.
// It then runs the second add/subtract butterfly through its own L-deep
// feedback shift register. The stage keeps its own sample counter and valid
// tracking, so the input stream may stall at any time without losing frame
// alignment.
//
// Parameters
//   DW            : width of the real and imaginary parts (input and output)
//   SHIFT_REG_LEN : feedback delay L, a power of two >= 1 (block = 4*L)
//
// Ports
//   clk_i       in   clock
//   rst_n       in   synchronous active-low reset
//   valid_i     in   input sample present this cycle (always accepted)
//   x_re_i      in   signed real input, DW bits
//   x_im_i      in   signed imaginary input, DW bits
//   valid_o     out  z_re_o / z_im_o hold a valid sample
//   z_re_o      out  signed real output, registered
//   z_im_o      out  signed imaginary output, registered
//   quarter_o   out  block quarter of the sample accepted on the previous cycle
//
// Build option
//   FFT_R22SDF_BFII_SAT_EN : when defined, butterfly results saturate from
//                            DW+1 to DW bits. Otherwise they wrap
//                            (two's-complement truncation).
// -----------------------------------------------------------------------------
module fft_r22sdf_bfii #(
    parameter int DW            = 25,
    parameter int SHIFT_REG_LEN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] x_re_i,
    input  logic signed [DW-1:0] x_im_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] z_re_o,
    output logic signed [DW-1:0] z_im_o,
    output logic [1:0]           quarter_o
);

    // Counter layout: the low LW bits index within a quarter, the top two
    // bits select the quarter.
    localparam int LW = $clog2(SHIFT_REG_LEN);
    localparam int CW = LW + 2;
    localparam logic [CW-1:0] PRIME_LAST = CW'(SHIFT_REG_LEN - 1);

    // Sign-extend a DW-bit value into the DW+1-bit butterfly domain.
    function automatic logic signed [DW:0] ext(input logic signed [DW-1:0] v);
        ext = {v[DW-1], v};
    endfunction

    // Bring a DW+1-bit butterfly result back to DW bits.
    function automatic logic signed [DW-1:0] reduce(input logic signed [DW:0] v);
`ifdef FFT_R22SDF_BFII_SAT_EN
        // The top two bits disagree only when the value does not fit in DW bits.
        if (v[DW] != v[DW-1]) begin
            if (v[DW]) begin
                reduce = {1'b1, {(DW-1){1'b0}}};
            end else begin
                reduce = {1'b0, {(DW-1){1'b1}}};
            end
        end else begin
            reduce = v[DW-1:0];
        end
`else
        logic unused_msb_s;
        unused_msb_s = v[DW];
        reduce       = v[DW-1:0];
`endif
    endfunction

    logic [CW-1:0]        ctr_r;
    logic                 primed_r;
    logic signed [DW-1:0] sr_re_r [SHIFT_REG_LEN];
    logic signed [DW-1:0] sr_im_r [SHIFT_REG_LEN];

    logic signed [DW-1:0] z_re_r;
    logic signed [DW-1:0] z_im_r;
    logic [1:0]           quarter_r;
    logic                 valid_r;

    logic [1:0]           q_s;
    logic                 sel_s;
    logic                 rot_s;
    logic signed [DW:0]   xr_s;
    logic signed [DW:0]   xi_s;
    logic signed [DW:0]   sro_re_s;
    logic signed [DW:0]   sro_im_s;
    logic signed [DW:0]   sum_re_s;
    logic signed [DW:0]   sum_im_s;
    logic signed [DW:0]   dif_re_s;
    logic signed [DW:0]   dif_im_s;
    logic signed [DW-1:0] out_re_s;
    logic signed [DW-1:0] out_im_s;
    logic signed [DW-1:0] fb_re_s;
    logic signed [DW-1:0] fb_im_s;

    assign q_s   = ctr_r[CW-1:CW-2];
    assign sel_s = q_s[0];
    assign rot_s = (q_s == 2'd3);

    // Trivial -j rotation in the last quarter: (re, im) -> (im, -re).
    // The result is DW+1 bits wide so negating the most negative input
    // cannot overflow.
    always_comb begin
        xr_s = ext(x_re_i);
        xi_s = ext(x_im_i);
        if (rot_s) begin
            xr_s = ext(x_im_i);
            xi_s = -ext(x_re_i);
        end else begin
            xr_s = ext(x_re_i);
            xi_s = ext(x_im_i);
        end
    end

    // Second butterfly. The oldest shift-register entry pairs with the
    // current sample in odd quarters. In even quarters it is drained and the
    // new sample is parked in the delay line.
    always_comb begin
        sro_re_s = ext(sr_re_r[SHIFT_REG_LEN-1]);
        sro_im_s = ext(sr_im_r[SHIFT_REG_LEN-1]);
        sum_re_s = sro_re_s + xr_s;
        sum_im_s = sro_im_s + xi_s;
        dif_re_s = sro_re_s - xr_s;
        dif_im_s = sro_im_s - xi_s;
        out_re_s = reduce(sro_re_s);
        out_im_s = reduce(sro_im_s);
        fb_re_s  = reduce(xr_s);
        fb_im_s  = reduce(xi_s);
        if (sel_s) begin
            out_re_s = reduce(sum_re_s);
            out_im_s = reduce(sum_im_s);
            fb_re_s  = reduce(dif_re_s);
            fb_im_s  = reduce(dif_im_s);
        end else begin
            out_re_s = reduce(sro_re_s);
            out_im_s = reduce(sro_im_s);
            fb_re_s  = reduce(xr_s);
            fb_im_s  = reduce(xi_s);
        end
    end

    // Sample counter and priming flag. Both advance only on accepted samples.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            ctr_r    <= {CW{1'b0}};
            primed_r <= 1'b0;
        end else if (valid_i) begin
            // The counter is exactly log2(4L) bits, so it wraps at 4L.
            ctr_r <= ctr_r + {{(CW-1){1'b0}}, 1'b1};
            // Once the L-th sample since reset is accepted, the delay line
            // holds real data, and every later sample yields a valid output.
            if (ctr_r == PRIME_LAST) begin
                primed_r <= 1'b1;
            end else begin
                primed_r <= primed_r;
            end
        end else begin
            ctr_r    <= ctr_r;
            primed_r <= primed_r;
        end
    end

    // Feedback delay line. It shifts one place per accepted sample and holds
    // during stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                sr_re_r[i] <= {DW{1'b0}};
                sr_im_r[i] <= {DW{1'b0}};
            end
        end else if (valid_i) begin
            for (int i = SHIFT_REG_LEN - 1; i > 0; i--) begin
                sr_re_r[i] <= sr_re_r[i-1];
                sr_im_r[i] <= sr_im_r[i-1];
            end
            sr_re_r[0] <= fb_re_s;
            sr_im_r[0] <= fb_im_s;
        end else begin
            for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                sr_re_r[i] <= sr_re_r[i];
                sr_im_r[i] <= sr_im_r[i];
            end
        end
    end

    // Output register. Data and quarter hold across stalls; valid drops.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            z_re_r    <= {DW{1'b0}};
            z_im_r    <= {DW{1'b0}};
            quarter_r <= 2'd0;
            valid_r   <= 1'b0;
        end else if (valid_i) begin
            z_re_r    <= out_re_s;
            z_im_r    <= out_im_s;
            quarter_r <= q_s;
            valid_r   <= primed_r;
        end else begin
            z_re_r    <= z_re_r;
            z_im_r    <= z_im_r;
            quarter_r <= quarter_r;
            valid_r   <= 1'b0;
        end
    end

    assign z_re_o    = z_re_r;
    assign z_im_o    = z_im_r;
    assign quarter_o = quarter_r;
    assign valid_o   = valid_r;

endmodule

// File: tb/tb_fft_r22sdf_bfii.sv
// -----------------------------------------------------------------------------
// Testbench for fft_r22sdf_bfii. Four instances with different (DW, L):
//   0: DW=8,  L=1    1: DW=16, L=4    2: DW=8, L=2    3: DW=8, L=8
// The reference model works on whole integers. It uses a FIFO of length L,
// a running sample index for the quarter, and a clamp or modular wrap,
// depending on FFT_R22SDF_BFII_SAT_EN.
// -----------------------------------------------------------------------------
module tb_fft_r22sdf_bfii;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_a [4];
    logic               vin   [4];
    logic signed [31:0] xre_a [4];
    logic signed [31:0] xim_a [4];

    logic signed [7:0]  z0_re, z0_im, z2_re, z2_im, z3_re, z3_im;
    logic signed [15:0] z1_re, z1_im;
    logic [1:0]         q0, q1, q2, q3;
    logic               v0, v1, v2, v3;

    fft_r22sdf_bfii #(.DW(8), .SHIFT_REG_LEN(1)) u_l1 (
        .clk_i(clk), .rst_n(rst_a[0]), .valid_i(vin[0]),
        .x_re_i(xre_a[0][7:0]), .x_im_i(xim_a[0][7:0]),
        .valid_o(v0), .z_re_o(z0_re), .z_im_o(z0_im), .quarter_o(q0));

    fft_r22sdf_bfii #(.DW(16), .SHIFT_REG_LEN(4)) u_l4 (
        .clk_i(clk), .rst_n(rst_a[1]), .valid_i(vin[1]),
        .x_re_i(xre_a[1][15:0]), .x_im_i(xim_a[1][15:0]),
        .valid_o(v1), .z_re_o(z1_re), .z_im_o(z1_im), .quarter_o(q1));

    fft_r22sdf_bfii #(.DW(8), .SHIFT_REG_LEN(2)) u_l2 (
        .clk_i(clk), .rst_n(rst_a[2]), .valid_i(vin[2]),
        .x_re_i(xre_a[2][7:0]), .x_im_i(xim_a[2][7:0]),
        .valid_o(v2), .z_re_o(z2_re), .z_im_o(z2_im), .quarter_o(q2));

    fft_r22sdf_bfii #(.DW(8), .SHIFT_REG_LEN(8)) u_l8 (
        .clk_i(clk), .rst_n(rst_a[3]), .valid_i(vin[3]),
        .x_re_i(xre_a[3][7:0]), .x_im_i(xim_a[3][7:0]),
        .valid_o(v3), .z_re_o(z3_re), .z_im_o(z3_im), .quarter_o(q3));

    integer zre [4];
    integer zim [4];
    integer zq  [4];
    logic   zv  [4];

    always_comb begin
        zre[0] = z0_re; zim[0] = z0_im; zq[0] = q0; zv[0] = v0;
        zre[1] = z1_re; zim[1] = z1_im; zq[1] = q1; zv[1] = v1;
        zre[2] = z2_re; zim[2] = z2_im; zq[2] = q2; zv[2] = v2;
        zre[3] = z3_re; zim[3] = z3_im; zq[3] = q3; zv[3] = v3;
    end

    // ---------------- reference model ----------------
    int   m_dw [4] = '{8, 16, 8, 8};
    int   m_l  [4] = '{1, 4, 2, 8};
    int   m_n  [4];
    int   m_ptr[4];
    int   m_fre[4][8];
    int   m_fim[4][8];
    int   e_re [4];
    int   e_im [4];
    int   e_q  [4];
    logic e_v  [4];

    int n_cmp = 0;
    int n_err = 0;

`ifdef FFT_R22SDF_BFII_SAT_EN
    function automatic int fit(int v, int dw);
        int hi;
        int lo;
        hi = (1 << (dw - 1)) - 1;
        lo = -(1 << (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
`else
    function automatic int fit(int v, int dw);
        int m;
        int r;
        m = 1 << dw;
        r = ((v % m) + m) % m;
        if (r >= (m / 2)) r = r - m;
        return r;
    endfunction
`endif

    function automatic int rnd(int dw);
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return -(1 << (dw - 1));
        if (sel == 1) return (1 << (dw - 1)) - 1;
        return int'($urandom_range(0, (1 << dw) - 1)) - (1 << (dw - 1));
    endfunction

    task automatic model_reset(int i);
        m_n[i]   = 0;
        m_ptr[i] = 0;
        for (int j = 0; j < 8; j++) begin
            m_fre[i][j] = 0;
            m_fim[i][j] = 0;
        end
        e_re[i] = 0; e_im[i] = 0; e_q[i] = 0; e_v[i] = 1'b0;
    endtask

    task automatic model_step(int i, logic v, int re, int im);
        int ll, q, xr, xi, sr, si, o_r, o_i, f_r, f_i;
        if (!v) begin
            e_v[i] = 1'b0;
        end else begin
            ll = m_l[i];
            q  = (m_n[i] % (4 * ll)) / ll;
            xr = re; xi = im;
            if (q == 3) begin xr = im; xi = -re; end
            sr = m_fre[i][m_ptr[i]];
            si = m_fim[i][m_ptr[i]];
            if (q % 2 == 1) begin
                o_r = sr + xr; o_i = si + xi; f_r = sr - xr; f_i = si - xi;
            end else begin
                o_r = sr; o_i = si; f_r = xr; f_i = xi;
            end
            e_re[i] = fit(o_r, m_dw[i]);
            e_im[i] = fit(o_i, m_dw[i]);
            e_q[i]  = q;
            e_v[i]  = (m_n[i] >= ll);
            m_fre[i][m_ptr[i]] = fit(f_r, m_dw[i]);
            m_fim[i][m_ptr[i]] = fit(f_i, m_dw[i]);
            m_ptr[i] = (m_ptr[i] + 1) % ll;
            m_n[i]   = m_n[i] + 1;
        end
    endtask

    // One clock for instance i; outputs are settled at return (negedge).
    task automatic drive(int i, logic v, int re, int im);
        vin[i]   = v;
        xre_a[i] = re;
        xim_a[i] = im;
        model_step(i, v, re, im);
        @(posedge clk);
        @(negedge clk);
        vin[i] = 1'b0;
    endtask

    // One reset cycle with valid_i high to show it is ignored.
    task automatic apply_reset(int i);
        rst_a[i] = 1'b0;
        vin[i]   = 1'b1;
        xre_a[i] = rnd(m_dw[i]);
        xim_a[i] = rnd(m_dw[i]);
        @(posedge clk);
        @(negedge clk);
        rst_a[i] = 1'b1;
        vin[i]   = 1'b0;
        model_reset(i);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b0; vin[i] = 1'b1; xre_a[i] = 7; xim_a[i] = -3;
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b1; vin[i] = 1'b0;
            model_reset(i);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (zv[i] !== 1'b0 || zre[i] !== 0 || zim[i] !== 0 || zq[i] !== 0) begin
                n_err++;
                $display("FAIL reset inst=%0d got v=%b re=%0d im=%0d q=%0d, want all 0",
                         i, zv[i], zre[i], zim[i], zq[i]);
            end
        end
    endtask

    task automatic test_basic();
        int in_re [5] = '{10, 3, 5, 2, 10};
        int in_im [5] = '{0, 0, 0, 1, 0};
        int w_v   [5] = '{0, 1, 1, 1, 1};
        int w_re  [5] = '{0, 13, 7, 6, 4};
        int w_im  [5] = '{0, 0, 0, -2, 2};
        int w_q   [5] = '{0, 1, 2, 3, 0};
        apply_reset(0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, in_re[k], in_im[k]);
            n_cmp++;
            if (zv[0] !== w_v[k][0] || zre[0] !== w_re[k] || zim[0] !== w_im[k] || zq[0] !== w_q[k]) begin
                n_err++;
                $display("FAIL basic step=%0d got v=%b re=%0d im=%0d q=%0d, want v=%0d re=%0d im=%0d q=%0d",
                         k, zv[0], zre[0], zim[0], zq[0], w_v[k], w_re[k], w_im[k], w_q[k]);
            end
        end
    endtask

    task automatic test_stall();
        int in_v  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int in_re [8] = '{10, 3, 7, -7, 99, 5, 2, 10};
        int in_im [8] = '{0, 0, 9, -9, 33, 0, 1, 0};
        int w_v   [8] = '{0, 1, 0, 0, 0, 1, 1, 1};
        int w_re  [8] = '{0, 13, 13, 13, 13, 7, 6, 4};
        int w_im  [8] = '{0, 0, 0, 0, 0, 0, -2, 2};
        int w_q   [8] = '{0, 1, 1, 1, 1, 2, 3, 0};
        apply_reset(0);
        for (int k = 0; k < 8; k++) begin
            drive(0, in_v[k][0], in_re[k], in_im[k]);
            n_cmp++;
            if (zv[0] !== w_v[k][0] || zre[0] !== w_re[k] || zim[0] !== w_im[k] || zq[0] !== w_q[k]) begin
                n_err++;
                $display("FAIL stall step=%0d got v=%b re=%0d im=%0d q=%0d, want v=%0d re=%0d im=%0d q=%0d",
                         k, zv[0], zre[0], zim[0], zq[0], w_v[k], w_re[k], w_im[k], w_q[k]);
            end
        end
    endtask

    task automatic test_long_delay();
        apply_reset(1);
        for (int k = 0; k < 64; k++) begin
            drive(1, 1'b1, k % 16, 15 - (k % 16));
            n_cmp++;
            if (zv[1] !== e_v[1] || zre[1] !== e_re[1] || zim[1] !== e_im[1] || zq[1] !== e_q[1]
                || zv[1] !== (k >= 4) || zq[1] !== ((k % 16) / 4)) begin
                n_err++;
                $display("FAIL long_delay k=%0d got v=%b re=%0d im=%0d q=%0d, want v=%b re=%0d im=%0d q=%0d",
                         k, zv[1], zre[1], zim[1], zq[1], e_v[1], e_re[1], e_im[1], e_q[1]);
            end
        end
    endtask

    task automatic test_rot_overflow();
        int in_re [5] = '{0, 0, -128, -128, 0};
        int in_im [5] = '{0, 0, -128, -128, 0};
`ifdef FFT_R22SDF_BFII_SAT_EN
        int w3_re = -128; int w3_im = 0; int w4_re = 0; int w4_im = -128;
`else
        int w3_re = 0;    int w3_im = 0; int w4_re = 0; int w4_im = 0;
`endif
        apply_reset(0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, in_re[k], in_im[k]);
            n_cmp++;
            if (zv[0] !== e_v[0] || zre[0] !== e_re[0] || zim[0] !== e_im[0] || zq[0] !== e_q[0]
                || (k == 3 && (zre[0] !== w3_re || zim[0] !== w3_im))
                || (k == 4 && (zre[0] !== w4_re || zim[0] !== w4_im))) begin
                n_err++;
                $display("FAIL rot_overflow step=%0d got v=%b re=%0d im=%0d q=%0d, model v=%b re=%0d im=%0d q=%0d",
                         k, zv[0], zre[0], zim[0], zq[0], e_v[0], e_re[0], e_im[0], e_q[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(1);
        for (int k = 0; k < 18; k++) begin
            drive(1, 1'b1, rnd(16), rnd(16));
            n_cmp++;
            if (zv[1] !== e_v[1] || zre[1] !== e_re[1] || zim[1] !== e_im[1] || zq[1] !== e_q[1]) begin
                n_err++;
                $display("FAIL mid_reset_pre k=%0d got v=%b re=%0d im=%0d q=%0d, want v=%b re=%0d im=%0d q=%0d",
                         k, zv[1], zre[1], zim[1], zq[1], e_v[1], e_re[1], e_im[1], e_q[1]);
            end
        end
        apply_reset(1);
        n_cmp++;
        if (zv[1] !== 1'b0 || zre[1] !== 0 || zim[1] !== 0 || zq[1] !== 0) begin
            n_err++;
            $display("FAIL mid_reset_clear got v=%b re=%0d im=%0d q=%0d, want all 0",
                     zv[1], zre[1], zim[1], zq[1]);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 1'b1, rnd(16), rnd(16));
            n_cmp++;
            if (zv[1] !== e_v[1] || zre[1] !== e_re[1] || zim[1] !== e_im[1] || zq[1] !== e_q[1]
                || zv[1] !== (k >= 4)) begin
                n_err++;
                $display("FAIL mid_reset_post k=%0d got v=%b re=%0d im=%0d q=%0d, want v=%b re=%0d im=%0d q=%0d",
                         k, zv[1], zre[1], zim[1], zq[1], e_v[1], e_re[1], e_im[1], e_q[1]);
            end
        end
    endtask

    task automatic test_soak();
        int inst [3] = '{0, 2, 3};
        int i;
        for (int s = 0; s < 3; s++) begin
            i = inst[s];
            apply_reset(i);
            for (int c = 0; c < 6700; c++) begin
                drive(i, 1'($urandom_range(0, 1)), rnd(m_dw[i]), rnd(m_dw[i]));
                n_cmp++;
                if (zv[i] !== e_v[i] || zre[i] !== e_re[i] || zim[i] !== e_im[i] || zq[i] !== e_q[i]) begin
                    n_err++;
                    $display("FAIL soak inst=%0d cyc=%0d got v=%b re=%0d im=%0d q=%0d, want v=%b re=%0d im=%0d q=%0d",
                             i, c, zv[i], zre[i], zim[i], zq[i], e_v[i], e_re[i], e_im[i], e_q[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b0; vin[i] = 1'b0; xre_a[i] = 0; xim_a[i] = 0;
            model_reset(i);
        end
        test_reset();
        test_basic();
        test_stall();
        test_long_delay();
        test_rot_overflow();
        test_mid_reset();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
